// File: rtl/demux_scheduler.sv
// demux_scheduler: single-word holding register that routes each accepted
// source word to one of eight sink channels, either round-robin over the
// enabled channels or to an explicitly addressed channel.
module demux_scheduler #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic          mode,
    input  logic [2:0]    in_sel,
    input  logic [7:0]    ch_en,
    output logic [7:0]    out_valid,
    output logic [DW-1:0] out_data,
    input  logic [7:0]    out_ready,
    output logic [2:0]    sel_q,
    output logic          drop
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t        state_r;
    logic [2:0]    rr_ptr_r;
    logic [2:0]    sel_q_r;
    logic [DW-1:0] out_data_r;
    logic [7:0]    out_valid_r;
    logic          drop_r;

    logic [2:0]    rr_tgt_s;
    logic [2:0]    tgt_s;
    logic          tgt_en_s;
    logic          room_s;
    logic          done_s;
    logic          in_ready_s;
    logic          accept_s;

    // First enabled channel at or above ptr, wrapping modulo 8.
    function automatic logic [2:0] rr_pick(input logic [2:0] ptr, input logic [7:0] en);
        logic [2:0] pick;
        logic [2:0] idx;
        pick = ptr;
        // Walk offsets from farthest to nearest so the nearest enabled wins.
        for (int i = 7; i >= 0; i--) begin
            idx = ptr + 3'(i);
            if (en[idx]) begin
                pick = idx;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'h01 << idx;
    endfunction

    // Target selection, completion and handshake decode.
    always_comb begin
        rr_tgt_s = rr_pick(rr_ptr_r, ch_en);
        if (mode) begin
            tgt_s = in_sel;
        end else begin
            tgt_s = rr_tgt_s;
        end
        tgt_en_s = ch_en[tgt_s];
        case (state_r)
            IDLE:    room_s = 1'b1;
            HOLD:    room_s = out_ready[sel_q_r];
            default: room_s = 1'b0;
        endcase
        done_s     = (state_r == HOLD) && out_ready[sel_q_r];
        in_ready_s = room_s && (mode || (ch_en != 8'h00));
        accept_s   = in_valid && in_ready_s;
    end

    // Holding register, routing state and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            rr_ptr_r    <= 3'd0;
            sel_q_r     <= 3'd0;
            out_data_r  <= '0;
            out_valid_r <= 8'h00;
            drop_r      <= 1'b0;
        end else begin
            drop_r <= 1'b0;
            if (accept_s) begin
                if (tgt_en_s) begin
                    out_data_r  <= in_data;
                    sel_q_r     <= tgt_s;
                    state_r     <= HOLD;
                    out_valid_r <= onehot8(tgt_s);
                end else begin
                    // Addressed word to a disabled channel is consumed and reported.
                    drop_r      <= 1'b1;
                    state_r     <= IDLE;
                    out_valid_r <= 8'h00;
                end
                if (!mode) begin
                    rr_ptr_r <= tgt_s + 3'd1;
                end else begin
                    rr_ptr_r <= rr_ptr_r;
                end
            end else if (done_s) begin
                state_r     <= IDLE;
                out_valid_r <= 8'h00;
            end else begin
                state_r     <= state_r;
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign sel_q     = sel_q_r;
    assign drop      = drop_r;

endmodule
